// File: rtl/dwt97_lifting_step.sv
`default_nettype none
// ============================================================================
// dwt97_lifting_step: one 9/7 DWT lifting step (predict or update) on a pair stream
// Revision: 1.0
// ============================================================================
module dwt97_lifting_step #(
  parameter int DataWidth = 16,
  parameter int CoefWidth = 16,
  parameter int FracBits  = 14,
  parameter int Coef      = -25987,
  parameter int Mode      = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  localparam int SUM_W  = DataWidth + 1;
  localparam int PROD_W = SUM_W + CoefWidth;
  localparam int RES_W  = PROD_W + 1;

  localparam logic signed [CoefWidth-1:0] COEF_S  = CoefWidth'(Coef);
  localparam logic signed [PROD_W-1:0]    HALF    = PROD_W'(1 << (FracBits - 1));
  localparam logic signed [RES_W-1:0]     SAT_MAX = RES_W'((1 << (DataWidth - 1)) - 1);
  localparam logic signed [RES_W-1:0]     SAT_MIN = RES_W'(-(1 << (DataWidth - 1)));

  // tgt + round(C*(a+b)), rounding half toward +inf, saturated to the sample range
  function automatic logic signed [DataWidth-1:0] lift(
    input logic signed [DataWidth-1:0] tgt,
    input logic signed [DataWidth-1:0] a,
    input logic signed [DataWidth-1:0] b
  );
    logic signed [SUM_W-1:0]  sum;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [RES_W-1:0]  res;
    sum  = SUM_W'(a) + SUM_W'(b);
    prod = PROD_W'(sum) * PROD_W'(COEF_S);
    rnd  = (prod + HALF) >>> FracBits;
    res  = RES_W'(tgt) + RES_W'(rnd);
    if (res > SAT_MAX) begin
      return SAT_MAX[DataWidth-1:0];
    end else if (res < SAT_MIN) begin
      return SAT_MIN[DataWidth-1:0];
    end
    return res[DataWidth-1:0];
  endfunction

  logic                          out_free;
  logic                          accept;
  logic                          out_load;
  logic                          out_sof;
  logic                          out_eol;
  logic [2*DataWidth-1:0]        out_data;
  logic signed [DataWidth-1:0]   in_e;
  logic signed [DataWidth-1:0]   in_o;

  logic                          m_valid_q;
  logic                          m_sof_q;
  logic                          m_eol_q;
  logic [2*DataWidth-1:0]        m_data_q;

  assign in_e     = s_data_i[DataWidth-1:0];
  assign in_o     = s_data_i[2*DataWidth-1:DataWidth];
  assign out_free = !m_valid_q || m_ready_i;
  assign accept   = s_valid_i && s_ready_o;

  generate
    if (Mode == 0) begin : g_predict
      localparam logic [1:0] ST_IDLE  = 2'd0;
      localparam logic [1:0] ST_HOLD  = 2'd1;
      localparam logic [1:0] ST_FLUSH = 2'd2;

      logic [1:0]                  state_q;
      logic [1:0]                  state_d;
      logic signed [DataWidth-1:0] hold_e_q;
      logic signed [DataWidth-1:0] hold_o_q;
      logic                        hold_sof_q;
      logic                        hold_load;

      assign s_ready_o = out_free && (state_q != ST_FLUSH);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q <= ST_IDLE;
        end else begin
          state_q <= state_d;
        end
      end

      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_IDLE:  if (accept && !s_eol_i) state_d = ST_HOLD;
          ST_HOLD:  if (accept && s_eol_i)  state_d = ST_FLUSH;
          ST_FLUSH: if (out_free)           state_d = ST_IDLE;
          default:                          state_d = ST_IDLE;
        endcase
      end

      // The held pair is emitted once its right neighbour arrives; the line's
      // last pair mirrors its own even sample (whole-sample symmetric edge).
      always_comb begin
        out_load  = 1'b0;
        out_sof   = 1'b0;
        out_eol   = 1'b0;
        out_data  = '0;
        hold_load = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              if (s_eol_i) begin
                out_load = 1'b1;
                out_sof  = s_sof_i;
                out_eol  = 1'b1;
                out_data = {lift(in_o, in_e, in_e), in_e};
              end else begin
                hold_load = 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (accept) begin
              out_load  = 1'b1;
              out_sof   = hold_sof_q;
              out_eol   = 1'b0;
              out_data  = {lift(hold_o_q, hold_e_q, in_e), hold_e_q};
              hold_load = 1'b1;
            end
          end
          ST_FLUSH: begin
            if (out_free) begin
              out_load = 1'b1;
              out_sof  = hold_sof_q;
              out_eol  = 1'b1;
              out_data = {lift(hold_o_q, hold_e_q, hold_e_q), hold_e_q};
            end
          end
          default: begin
            out_load = 1'b0;
          end
        endcase
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hold_e_q   <= '0;
          hold_o_q   <= '0;
          hold_sof_q <= 1'b0;
        end else if (hold_load) begin
          hold_e_q   <= in_e;
          hold_o_q   <= in_o;
          hold_sof_q <= s_sof_i;
        end
      end
    end else begin : g_update
      logic                        first_q;
      logic signed [DataWidth-1:0] prev_o_q;
      logic signed [DataWidth-1:0] left_o;

      // The first pair of a line has no left neighbour, so it mirrors its own odd.
      assign left_o    = first_q ? in_o : prev_o_q;
      assign s_ready_o = out_free;
      assign out_load  = accept;
      assign out_sof   = s_sof_i;
      assign out_eol   = s_eol_i;
      assign out_data  = {in_o, lift(in_e, left_o, in_o)};

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          first_q  <= 1'b1;
          prev_o_q <= '0;
        end else if (accept) begin
          first_q  <= s_eol_i;
          prev_o_q <= in_o;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_data_q  <= '0;
    end else if (out_load) begin
      m_valid_q <= 1'b1;
      m_sof_q   <= out_sof;
      m_eol_q   <= out_eol;
      m_data_q  <= out_data;
    end else if (m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_data_o  = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_dwt97_lifting_step.sv
`default_nettype none
// Bench for dwt97_lifting_step: spec vectors, backpressure/reset sequence and
// randomized lines checked against a per-line arithmetic model.
module tb_dwt97_lifting_step;

  localparam int FB = 14;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
  } pair_t;

  typedef struct packed {
    logic [1:0]       dut;
    logic [1:0]       n;
    logic [2:0][15:0] e;
    logic [2:0][15:0] o;
    logic [2:0][15:0] xe;
    logic [2:0][15:0] xo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        s_valid [3];
  logic        s_sof   [3];
  logic        s_eol   [3];
  logic [31:0] s_data  [3];
  logic        m_ready [3];
  logic        s_ready [3];
  logic        m_valid [3];
  logic        m_sof   [3];
  logic        m_eol   [3];
  logic [31:0] m_data  [3];

  pair_t stim_q[$];
  pair_t exp_q[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;

  // DUT 0: predict C=0.5, DUT 1: update C=0.5, DUT 2: predict C=-1.0
  for (genvar d = 0; d < 3; d++) begin : g_dut
    dwt97_lifting_step #(
      .DataWidth(16),
      .CoefWidth(16),
      .FracBits (14),
      .Coef     ((d == 2) ? -16384 : 8192),
      .Mode     ((d == 1) ? 1 : 0)
    ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .s_ready_o(s_ready[d]),
      .s_valid_i(s_valid[d]),
      .s_sof_i  (s_sof[d]),
      .s_eol_i  (s_eol[d]),
      .s_data_i (s_data[d]),
      .m_ready_i(m_ready[d]),
      .m_valid_o(m_valid[d]),
      .m_sof_o  (m_sof[d]),
      .m_eol_o  (m_eol[d]),
      .m_data_o (m_data[d])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_lift(input int t, input int a, input int b, input int coef);
    longint p;
    longint r;
    longint s;
    p = longint'(a + b) * longint'(coef);
    r = (p + (longint'(1) <<< (FB - 1))) >>> FB;
    s = longint'(t) + r;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic logic [31:0] pack(input int e, input int o);
    return {o[15:0], e[15:0]};
  endfunction

  function automatic vec_t mk(input int d, input int n,
                              input int e0, input int e1, input int e2,
                              input int o0, input int o1, input int o2,
                              input int x0, input int x1, input int x2,
                              input int y0, input int y1, input int y2);
    vec_t v;
    v.dut = d[1:0];  v.n = n[1:0];
    v.e[0] = e0[15:0];  v.e[1] = e1[15:0];  v.e[2] = e2[15:0];
    v.o[0] = o0[15:0];  v.o[1] = o1[15:0];  v.o[2] = o2[15:0];
    v.xe[0] = x0[15:0]; v.xe[1] = x1[15:0]; v.xe[2] = x2[15:0];
    v.xo[0] = y0[15:0]; v.xo[1] = y1[15:0]; v.xo[2] = y2[15:0];
    return v;
  endfunction

  // Reference: whole line at once, edges mirrored, then framing attached.
  task automatic push_line(input int mode, input int coef, input int e[$], input int o[$]);
    int    n;
    int    nb;
    pair_t p;
    n = e.size();
    for (int i = 0; i < n; i++) begin
      p.data = pack(e[i], o[i]);
      p.sof  = (i == 0);
      p.eol  = (i == n - 1);
      stim_q.push_back(p);
      if (mode == 0) begin
        nb = (i == n - 1) ? e[i] : e[i + 1];
        p.data = pack(e[i], ref_lift(o[i], e[i], nb, coef));
      end else begin
        nb = (i == 0) ? o[0] : o[i - 1];
        p.data = pack(ref_lift(e[i], nb, o[i], coef), o[i]);
      end
      exp_q.push_back(p);
    end
  endtask

  task automatic drive(input int d, input int e, input int o, input logic sof, input logic eol);
    s_valid[d] = 1'b1;
    s_data[d]  = pack(e, o);
    s_sof[d]   = sof;
    s_eol[d]   = eol;
  endtask

  task automatic run_stream(input int d, input int vp, input int rp);
    int          budget;
    bit          hold_chk;
    logic [31:0] last_data;
    pair_t       x;
    budget   = 0;
    hold_chk = 0;
    last_data = '0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
      m_ready[d] = ($urandom_range(99) < rp);
      if (stim_q.size() > 0 && $urandom_range(99) < vp) begin
        s_valid[d] = 1'b1;
        s_data[d]  = stim_q[0].data;
        s_sof[d]   = stim_q[0].sof;
        s_eol[d]   = stim_q[0].eol;
      end else begin
        s_valid[d] = 1'b0;
      end
      #1;
      if (hold_chk) begin
        chk("stall_valid", {31'b0, m_valid[d]}, 32'd1);
        chk("stall_data", m_data[d], last_data);
      end
      if (m_valid[d] && m_ready[d]) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", m_data[d], 32'hxxxx_xxxx);
        end else begin
          x = exp_q.pop_front();
          chk("out_data", m_data[d], x.data);
          chk("out_sof_eol", {30'b0, m_sof[d], m_eol[d]}, {30'b0, x.sof, x.eol});
        end
      end
      hold_chk  = m_valid[d] && !m_ready[d];
      last_data = m_data[d];
      if (s_valid[d] && s_ready[d]) void'(stim_q.pop_front());
    end
    @(negedge clk);
    s_valid[d] = 1'b0;
    m_ready[d] = 1'b1;
    if (budget >= 5000) begin
      chk("stream_timeout", {31'b0, 1'b1}, 32'd0);
      stim_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    pair_t p;
    for (int i = 0; i < int'(v.n); i++) begin
      p.data = {v.o[i], v.e[i]};
      p.sof  = (i == 0);
      p.eol  = (i == int'(v.n) - 1);
      stim_q.push_back(p);
      p.data = {v.xo[i], v.xe[i]};
      exp_q.push_back(p);
    end
    run_stream(int'(v.dut), 100, 100);
  endtask

  function automatic int rnd_sample();
    if ($urandom_range(3) == 0) return int'($urandom_range(65535)) - 32768;
    return int'($urandom_range(400)) - 200;
  endfunction

  initial begin
    int e[$];
    int o[$];
    int len;

    for (int d = 0; d < 3; d++) begin
      s_valid[d] = 1'b0; s_sof[d] = 1'b0; s_eol[d] = 1'b0;
      s_data[d]  = '0;   m_ready[d] = 1'b1;
    end
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_valid", {31'b0, m_valid[d]}, 32'd0);
      chk("reset_sof_eol", {30'b0, m_sof[d], m_eol[d]}, 32'd0);
      chk("reset_data", m_data[d], 32'd0);
      chk("reset_ready", {31'b0, s_ready[d]}, 32'd1);
    end
    @(negedge clk);
    rst_ni = 1'b1;

    vecs[0] = mk(0, 3, 10, 20, 30, 1, 2, 3, 10, 20, 30, 16, 27, 33);
    vecs[1] = mk(0, 2, 1, 2, 0, 0, 0, 0, 1, 2, 0, 2, 2, 0);
    vecs[2] = mk(0, 2, -1, -2, 0, 0, 0, 0, -1, -2, 0, -1, -2, 0);
    vecs[3] = mk(0, 1, 7, 0, 0, 1, 0, 0, 7, 0, 0, 8, 0, 0);
    vecs[4] = mk(1, 3, 0, 0, 0, 4, 6, 8, 4, 5, 7, 4, 6, 8);
    vecs[5] = mk(1, 1, 0, 0, 0, 2, 0, 0, 2, 0, 0, 2, 0, 0);
    vecs[6] = mk(0, 2, 32767, 32767, 0, 32767, 0, 0, 32767, 32767, 0, 32767, 32767, 0);
    vecs[7] = mk(2, 1, -32768, 0, 0, -32768, 0, 0, -32768, 0, 0, 32767, 0, 0);
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure while the last pair of a line is pending
    @(negedge clk); drive(0, 10, 1, 1'b1, 1'b0);
    @(negedge clk); drive(0, 20, 2, 1'b0, 1'b0);
    @(negedge clk); drive(0, 30, 3, 1'b0, 1'b1);
    @(negedge clk); s_valid[0] = 1'b0; m_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("flush_ready_low", {31'b0, s_ready[0]}, 32'd0);
      chk("flush_stall_data", m_data[0], pack(20, 27));
    end
    @(negedge clk); m_ready[0] = 1'b1;
    @(negedge clk); #1;
    chk("flush_out_data", m_data[0], pack(30, 33));
    chk("flush_out_eol", {30'b0, m_valid[0], m_eol[0]}, 32'd3);
    chk("idle_ready", {31'b0, s_ready[0]}, 32'd1);

    // Reset in the middle of a line
    @(negedge clk); drive(0, 10, 1, 1'b1, 1'b0);
    @(negedge clk); drive(0, 20, 2, 1'b0, 1'b0);
    @(negedge clk); s_valid[0] = 1'b0; m_ready[0] = 1'b0;
    #1;
    chk("midline_out", m_data[0], pack(10, 16));
    rst_ni = 1'b0;
    #1;
    chk("async_reset_valid", {31'b0, m_valid[0]}, 32'd0);
    chk("async_reset_data", m_data[0], 32'd0);
    @(negedge clk); rst_ni = 1'b1; m_ready[0] = 1'b1;
    run_vec(vecs[0]);

    // Randomized lines with random valid/ready gaps
    for (int d = 0; d < 3; d++) begin
      for (int l = 0; l < 25; l++) begin
        e.delete();
        o.delete();
        len = int'($urandom_range(6, 1));
        for (int k = 0; k < len; k++) begin
          e.push_back(rnd_sample());
          o.push_back(rnd_sample());
        end
        push_line((d == 1) ? 1 : 0, (d == 2) ? -16384 : 8192, e, o);
      end
      run_stream(d, 70, 70);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
